// File: rtl/ecc_correct.sv
// Hsiao (39,32) SEC-DED correction stage with registered valid/ready output,
// saturating CE/UE counters and a sticky first-error log. Define ECC_POISON_EN to poison UE data.
module ecc_correct #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [39:0]      in_word,
    input  logic [6:0]       in_syn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_spare,
    output logic             out_ce,
    output logic             out_ue,
    output logic [5:0]       out_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] ue_cnt,
    output logic             log_valid,
    output logic [6:0]       log_syn,
    output logic             log_ue
);

    localparam logic [5:0] POS_NONE = 6'd63;

    // Map a syndrome to the codeword bit whose H column it matches, or POS_NONE.
    function automatic logic [5:0] col_pos(input logic [6:0] s);
        logic [5:0] p;
        case (s)
            7'h07: p = 6'd0;   7'h0B: p = 6'd1;   7'h13: p = 6'd2;   7'h23: p = 6'd3;
            7'h43: p = 6'd4;   7'h0D: p = 6'd5;   7'h15: p = 6'd6;   7'h25: p = 6'd7;
            7'h45: p = 6'd8;   7'h70: p = 6'd9;   7'h68: p = 6'd10;  7'h64: p = 6'd11;
            7'h62: p = 6'd12;  7'h61: p = 6'd13;  7'h58: p = 6'd14;  7'h54: p = 6'd15;
            7'h52: p = 6'd16;  7'h51: p = 6'd17;  7'h0E: p = 6'd18;  7'h1C: p = 6'd19;
            7'h38: p = 6'd20;  7'h16: p = 6'd21;  7'h26: p = 6'd22;  7'h1A: p = 6'd23;
            7'h2A: p = 6'd24;  7'h32: p = 6'd25;  7'h49: p = 6'd26;  7'h29: p = 6'd27;
            7'h4A: p = 6'd28;  7'h19: p = 6'd29;  7'h4C: p = 6'd30;  7'h34: p = 6'd31;
            7'h01: p = 6'd32;  7'h02: p = 6'd33;  7'h04: p = 6'd34;  7'h08: p = 6'd35;
            7'h10: p = 6'd36;  7'h20: p = 6'd37;  7'h40: p = 6'd38;
            default: p = POS_NONE;
        endcase
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [5:0]  w_match;
    logic        w_ce;
    logic        w_ue;
    logic [5:0]  w_pos;
    logic [31:0] w_flip;
    logic [31:0] w_data;
    logic        w_spare;
    logic        w_acc;
    logic        w_err;
    logic        w_unused_chk;

    logic             r_vld_p1;
    logic [31:0]      r_data_p1;
    logic             r_spare_p1;
    logic             r_ce_p1;
    logic             r_ue_p1;
    logic [5:0]       r_pos_p1;
    logic [CNT_W-1:0] r_ce_cnt;
    logic [CNT_W-1:0] r_ue_cnt;
    logic             r_log_vld;
    logic [6:0]       r_log_syn;
    logic             r_log_ue;

    // Check bits only feed the syndrome upstream; they are not forwarded.
    assign w_unused_chk = ^in_word[38:32];

    assign w_match = col_pos(in_syn);
    assign w_ce    = (^in_syn) && (w_match != POS_NONE);
    assign w_ue    = (in_syn != 7'h00) && !w_ce;
    assign w_pos   = w_ce ? w_match : POS_NONE;
    // Bit 5 of the position is set for check bits and for "none".
    assign w_flip  = w_pos[5] ? 32'h0 : (32'h1 << w_pos[4:0]);

`ifdef ECC_POISON_EN
    assign w_data  = w_ue ? 32'hDEAD_BEEF : (in_word[31:0] ^ w_flip);
    assign w_spare = w_ue | in_word[39];
`else
    assign w_data  = in_word[31:0] ^ w_flip;
    assign w_spare = in_word[39];
`endif

    assign in_ready = !r_vld_p1 || out_ready;
    assign w_acc    = in_valid && in_ready;
    assign w_err    = w_acc && (w_ce || w_ue);

    // Stage p1: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_data_p1  <= 32'h0;
            r_spare_p1 <= 1'b0;
            r_ce_p1    <= 1'b0;
            r_ue_p1    <= 1'b0;
            r_pos_p1   <= POS_NONE;
        end else if (w_acc) begin
            r_vld_p1   <= 1'b1;
            r_data_p1  <= w_data;
            r_spare_p1 <= w_spare;
            r_ce_p1    <= w_ce;
            r_ue_p1    <= w_ue;
            r_pos_p1   <= w_pos;
        end else if (out_ready) begin
            r_vld_p1   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce_cnt  <= '0;
            r_ue_cnt  <= '0;
            r_log_vld <= 1'b0;
            r_log_syn <= 7'h00;
            r_log_ue  <= 1'b0;
        end else if (cnt_clr) begin
            // A clear coincident with an event restarts from that event.
            r_ce_cnt  <= (w_acc && w_ce) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            r_ue_cnt  <= (w_acc && w_ue) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            r_log_vld <= w_err;
            r_log_syn <= w_err ? in_syn : 7'h00;
            r_log_ue  <= w_err && w_ue;
        end else begin
            if (w_acc && w_ce) r_ce_cnt <= sat_inc(r_ce_cnt);
            if (w_acc && w_ue) r_ue_cnt <= sat_inc(r_ue_cnt);
            if (w_err && !r_log_vld) begin
                r_log_vld <= 1'b1;
                r_log_syn <= in_syn;
                r_log_ue  <= w_ue;
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_spare = r_spare_p1;
    assign out_ce    = r_ce_p1;
    assign out_ue    = r_ue_p1;
    assign out_pos   = r_pos_p1;
    assign ce_cnt    = r_ce_cnt;
    assign ue_cnt    = r_ue_cnt;
    assign log_valid = r_log_vld;
    assign log_syn   = r_log_syn;
    assign log_ue    = r_log_ue;

endmodule

// File: doc/ecc_correct.md
Name: ecc_correct

Overview:
- Stage directly downstream of the (39,32) Hsiao SEC-DED syndrome generator in the SRAM read path.
- Consumes the raw 40-bit codeword plus its 7-bit syndrome, corrects single-bit errors and flags double or multi-bit errors.
- Registers the result behind a valid/ready handshake.
- Keeps saturating CE/UE counters and a sticky first-error log for software.

Parameters:
- CNT_W, 16, width of each saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  codeword/syndrome pair present
- in_ready  out  1  stage can accept
- in_word  in  40  [31:0] data, [38:32] check bits, [39] spare
- in_syn  in  7  syndrome for in_word
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_data  out  32  corrected data
- out_spare  out  1  in_word[39], passed through
- out_ce  out  1  single error corrected
- out_ue  out  1  uncorrectable error
- out_pos  out  6  flipped bit: 0-38, or 63 when none
- cnt_clr  in  1  synchronous clear of counters and log
- ce_cnt  out  CNT_W  corrected-error count
- ue_cnt  out  CNT_W  uncorrectable count
- log_valid  out  1  first-error log holds an entry
- log_syn  out  7  syndrome of the first logged error
- log_ue  out  1  first logged error was uncorrectable

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except out_pos = 63. in_ready = 1 while out_valid = 0.
- H columns, written S6..S0 hex, data bits 0-31:
  - Bits 0-8: 07 0B 13 23 43 0D 15 25 45
  - Bits 9-17: 70 68 64 62 61 58 54 52 51
  - Bits 18-25: 0E 1C 38 16 26 1A 2A 32
  - Bits 26-31: 49 29 4A 19 4C 34
  - Check bit k (bit 32+k): column 1<<k.
- Decode (combinational on input):
  - syn == 0: clean.
  - Odd weight and equal to a column: CE. Flip that bit; out_pos = its index.
  - Odd weight with no matching column, or even nonzero weight: UE. out_data = raw in_word[31:0]; out_pos = 63.
  - A check-bit CE leaves data unchanged; out_pos = 32-38.
- Pipeline:
  - Single output register, latency 1 cycle.
  - in_ready = !out_valid | out_ready.
  - Accept when in_valid & in_ready; the register loads on accept.
  - out_valid drops on out_ready when nothing new is accepted.
  - Full throughput under continuous out_ready.
  - Outputs stay stable while out_valid & !out_ready.
- Counters:
  - Increment only on an accepted CE/UE.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr coincident with an event: counter loads 1.
- Log:
  - On the first accepted error while log_valid = 0, capture log_syn and log_ue and set log_valid.
  - Later errors are ignored until cleared.
  - cnt_clr coincident with an error: log reloads with that error.
- rst_n asserted mid-transfer: the pending result is discarded; no partial state survives.

Optional Feature:
- Macro: ECC_POISON_EN.
- Defined: on UE, out_data = 32'hDEAD_BEEF and out_spare is forced to 1 as a poison marker.
- Undefined: on UE, raw data and spare pass through unmodified; out_ue is still asserted.

Test Plan:
- Clean word 0x00_12345678 with syn 0x00 -> out_data 0x12345678, out_ce = 0, out_ue = 0, out_pos = 63, 1-cycle latency.
- Data bit 13 flipped (0x00_12347678) with syn 0x61 -> out_data 0x12345678, out_ce = 1, out_pos = 13, ce_cnt = 1, log_syn = 0x61, log_valid = 1.
- Check bit 2 flipped with syn 0x04 -> data unchanged, out_ce = 1, out_pos = 34.
- Bits 0 and 1 flipped with syn 0x0C -> out_ue = 1, ue_cnt = 1, log_ue = 1. Also syn 0x07 followed by syn 0x7F -> CE then UE; log keeps 0x07.
- out_ready held low for 5 cycles with in_valid high -> in_ready = 0, outputs stable, no loss or duplication; 10-word stream at full rate with ready high -> 10 outputs in order.
- CNT_W = 2, 5 CEs -> ce_cnt stops at 3. cnt_clr with a CE in the same cycle -> ce_cnt = 1. rst_n pulsed mid-stream -> all outputs return to reset values immediately.
